// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-back cache controller:
// status bit positions, controller state encoding and derived widths.
package cache_pkg;

    localparam int WORD_W   = 32;
    localparam int STATUS_W = 3;
    localparam int ST_VALID = 0;
    localparam int ST_DIRTY = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_REFILL,
        S_REFILL_WAIT,
        S_FILL
    } state_t;

    function automatic int words_per_line(input int offset_len);
        return 2 ** (offset_len - 2);
    endfunction

    function automatic int line_width(input int offset_len);
        return WORD_W * words_per_line(offset_len);
    endfunction

    function automatic int addr_width(input int tag_len, input int index_len, input int offset_len);
        return tag_len + index_len + offset_len;
    endfunction

endpackage

// File: rtl/cache_word_merge.sv
// Combinational word extract / word insert on one cache line.
// Word 0 sits in line bits [31:0]; sel picks the 32-bit word.
module cache_word_merge
    import cache_pkg::*;
#(
    parameter int OFFSET_LEN = 4
) (
    input  logic [line_width(OFFSET_LEN)-1:0] line,
    input  logic [OFFSET_LEN-3:0]             sel,
    input  logic [WORD_W-1:0]                 wdata,
    output logic [WORD_W-1:0]                 word,
    output logic [line_width(OFFSET_LEN)-1:0] merged
);

    // bit offset of the selected word: sel * 32
    logic [OFFSET_LEN+2:0] bit_lo;
    assign bit_lo = {sel, 5'd0};

    assign word = line[bit_lo +: WORD_W];

    // replace the selected word, keep the rest of the line
    always_comb begin
        merged = line;
        merged[bit_lo +: WORD_W] = wdata;
    end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller.
// Optional build macro CACHE_STATS_EN adds hit_count / miss_count outputs.
module cache_controller
    import cache_pkg::*;
#(
    parameter int TAG_LEN    = 13,
    parameter int INDEX_LEN  = 10,
    parameter int OFFSET_LEN = 4
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              cpu_req_valid,
    output logic                                              cpu_req_ready,
    input  logic                                              cpu_we,
    input  logic [addr_width(TAG_LEN,INDEX_LEN,OFFSET_LEN)-1:0] cpu_addr,
    input  logic [WORD_W-1:0]                                 cpu_wdata,
    output logic                                              cpu_rvalid,
    output logic [WORD_W-1:0]                                 cpu_rdata,
    output logic                                              tag_we,
    output logic                                              tag_re,
    output logic [INDEX_LEN-1:0]                              tag_addr,
    output logic [TAG_LEN-1:0]                                tag_wr,
    output logic [STATUS_W-1:0]                               status_wr,
    input  logic [TAG_LEN-1:0]                                tag_rd,
    input  logic [STATUS_W-1:0]                               status_rd,
    output logic                                              data_we,
    output logic                                              data_re,
    output logic [INDEX_LEN-1:0]                              data_addr,
    output logic [line_width(OFFSET_LEN)-1:0]                 data_wr,
    input  logic [line_width(OFFSET_LEN)-1:0]                 data_rd,
    output logic                                              mem_req_valid,
    input  logic                                              mem_req_ready,
    output logic                                              mem_we,
    output logic [TAG_LEN+INDEX_LEN-1:0]                      mem_addr,
    output logic [line_width(OFFSET_LEN)-1:0]                 mem_wdata,
    input  logic                                              mem_rvalid,
    input  logic [line_width(OFFSET_LEN)-1:0]                 mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                                       hit_count,
    output logic [31:0]                                       miss_count
`endif
);

    localparam int LINE_W = line_width(OFFSET_LEN);
    localparam int ADDR_W = addr_width(TAG_LEN, INDEX_LEN, OFFSET_LEN);

    state_t state, state_next;

    logic                  req_we;
    logic [TAG_LEN-1:0]    req_tag;
    logic [INDEX_LEN-1:0]  req_index;
    logic [OFFSET_LEN-3:0] req_sel;
    logic [WORD_W-1:0]     req_wdata;
    logic [TAG_LEN-1:0]    old_tag;
    logic [LINE_W-1:0]     line_buf;

    logic [TAG_LEN-1:0]    cpu_tag;
    logic [INDEX_LEN-1:0]  cpu_index;
    logic                  accept;
    logic                  hit;
    logic                  victim_dirty;
    logic [LINE_W-1:0]     merge_src;
    logic [LINE_W-1:0]     merged_line;
    logic [WORD_W-1:0]     sel_word;

    // byte lane bits and the reserved status bit carry no information here
    logic unused_bits;
    assign unused_bits = ^{cpu_addr[1:0], status_rd[2]};

    assign cpu_tag      = cpu_addr[ADDR_W-1 -: TAG_LEN];
    assign cpu_index    = cpu_addr[OFFSET_LEN +: INDEX_LEN];
    assign accept       = cpu_req_valid && cpu_req_ready;
    assign hit          = status_rd[ST_VALID] && (tag_rd == req_tag);
    assign victim_dirty = status_rd[ST_VALID] && status_rd[ST_DIRTY];

    // FILL works on the refilled line, COMPARE on the line just read from RAM
    assign merge_src = (state == S_FILL) ? line_buf : data_rd;

    cache_word_merge #(
        .OFFSET_LEN(OFFSET_LEN)
    ) u_merge (
        .line  (merge_src),
        .sel   (req_sel),
        .wdata (req_wdata),
        .word  (sel_word),
        .merged(merged_line)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:        if (cpu_req_valid) state_next = S_COMPARE;
            S_COMPARE: begin
                if (hit)               state_next = S_IDLE;
                else if (victim_dirty) state_next = S_WRITEBACK;
                else                   state_next = S_REFILL;
            end
            S_WRITEBACK:   if (mem_req_ready) state_next = S_REFILL;
            S_REFILL:      if (mem_req_ready) state_next = S_REFILL_WAIT;
            S_REFILL_WAIT: if (mem_rvalid)    state_next = S_FILL;
            S_FILL:        state_next = S_IDLE;
            default:       state_next = S_IDLE;
        endcase
    end

    // outputs; everything is held low while reset is asserted
    always_comb begin
        cpu_req_ready = 1'b0;
        cpu_rvalid    = 1'b0;
        cpu_rdata     = '0;
        tag_we        = 1'b0;
        tag_re        = 1'b0;
        tag_addr      = '0;
        tag_wr        = '0;
        status_wr     = '0;
        data_we       = 1'b0;
        data_re       = 1'b0;
        data_addr     = '0;
        data_wr       = '0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        if (!reset) begin
            case (state)
                S_IDLE: begin
                    cpu_req_ready = 1'b1;
                    if (cpu_req_valid) begin
                        tag_re    = 1'b1;
                        data_re   = 1'b1;
                        tag_addr  = cpu_index;
                        data_addr = cpu_index;
                    end
                end
                S_COMPARE: begin
                    if (hit) begin
                        cpu_rvalid = 1'b1;
                        if (req_we) begin
                            tag_we    = 1'b1;
                            data_we   = 1'b1;
                            tag_addr  = req_index;
                            data_addr = req_index;
                            tag_wr    = req_tag;
                            status_wr = 3'b011;
                            data_wr   = merged_line;
                        end else begin
                            cpu_rdata = sel_word;
                        end
                    end
                end
                S_WRITEBACK: begin
                    mem_req_valid = 1'b1;
                    mem_we        = 1'b1;
                    mem_addr      = {old_tag, req_index};
                    mem_wdata     = line_buf;
                end
                S_REFILL: begin
                    mem_req_valid = 1'b1;
                    mem_addr      = {req_tag, req_index};
                end
                S_FILL: begin
                    tag_we     = 1'b1;
                    data_we    = 1'b1;
                    tag_addr   = req_index;
                    data_addr  = req_index;
                    tag_wr     = req_tag;
                    cpu_rvalid = 1'b1;
                    if (req_we) begin
                        status_wr = 3'b011;
                        data_wr   = merged_line;
                    end else begin
                        status_wr = 3'b001;
                        data_wr   = line_buf;
                        cpu_rdata = sel_word;
                    end
                end
                default: ;
            endcase
        end
    end

    // request, victim and refill capture; one buffer serves writeback and refill
    always_ff @(posedge clk) begin
        if (accept) begin
            req_we    <= cpu_we;
            req_tag   <= cpu_tag;
            req_index <= cpu_index;
            req_sel   <= cpu_addr[OFFSET_LEN-1:2];
            req_wdata <= cpu_wdata;
        end
        if (state == S_COMPARE && !hit && victim_dirty) begin
            line_buf <= data_rd;
            old_tag  <= tag_rd;
        end
        if (state == S_REFILL_WAIT && mem_rvalid) begin
            line_buf <= mem_rdata;
        end
    end

`ifdef CACHE_STATS_EN
    // hit/miss counters, updated once per lookup, wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == S_COMPARE) begin
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with behavioural tag/data RAMs
// (1-cycle registered read) and a hand-driven memory port.
module tb_cache_controller;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req_valid;
    logic         cpu_req_ready;
    logic         cpu_we;
    logic [26:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         cpu_rvalid;
    logic [31:0]  cpu_rdata;
    logic         tag_we, tag_re;
    logic [9:0]   tag_addr;
    logic [12:0]  tag_wr;
    logic [2:0]   status_wr;
    logic [12:0]  tag_rd;
    logic [2:0]   status_rd;
    logic         data_we, data_re;
    logic [9:0]   data_addr;
    logic [127:0] data_wr;
    logic [127:0] data_rd;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_we;
    logic [22:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_rvalid;
    logic [127:0] mem_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic ram_clr;

    logic [12:0]  tag_mem [1024];
    logic [2:0]   st_mem  [1024];
    logic [127:0] dat_mem [1024];

    localparam logic [127:0] L1  = {32'h33333333, 32'h22222222, 32'hCAFEF00D, 32'hDEADBEEF};
    localparam logic [127:0] L1S = {32'h33333333, 32'h22222222, 32'h12345678, 32'hDEADBEEF};
    localparam logic [127:0] L2  = {32'h44440003, 32'h44440002, 32'h44440001, 32'h44440000};
    localparam logic [127:0] L3  = {32'h55550003, 32'h55550002, 32'h55550001, 32'h55550000};

    cache_controller dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req_valid(cpu_req_valid),
        .cpu_req_ready(cpu_req_ready),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .tag_we       (tag_we),
        .tag_re       (tag_re),
        .tag_addr     (tag_addr),
        .tag_wr       (tag_wr),
        .status_wr    (status_wr),
        .tag_rd       (tag_rd),
        .status_rd    (status_rd),
        .data_we      (data_we),
        .data_re      (data_re),
        .data_addr    (data_addr),
        .data_wr      (data_wr),
        .data_rd      (data_rd),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 clk = ~clk;

    // behavioural single-port RAMs with registered read
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 1024; i++) st_mem[i] <= 3'b000;
        end else begin
            if (tag_we) begin
                tag_mem[tag_addr] <= tag_wr;
                st_mem[tag_addr]  <= status_wr;
            end
            if (tag_re) begin
                tag_rd    <= tag_mem[tag_addr];
                status_rd <= st_mem[tag_addr];
            end
            if (data_we) dat_mem[data_addr] <= data_wr;
            if (data_re) data_rd <= dat_mem[data_addr];
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one request in IDLE, check the RAM read strobe, land in COMPARE
    task automatic issue(input logic we, input logic [26:0] addr, input logic [31:0] wd);
        cpu_req_valid = 1'b1;
        cpu_we        = we;
        cpu_addr      = addr;
        cpu_wdata     = wd;
        #1;
        check("accept_tag_re", tag_re, 1'b1);
        check("accept_tag_addr", tag_addr, addr[13:4]);
        tick();
        cpu_req_valid = 1'b0;
        #1;
    endtask

    logic bad;

    initial begin
        reset         = 1'b1;
        ram_clr       = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_we        = 1'b0;
        cpu_addr      = '0;
        cpu_wdata     = '0;
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        repeat (2) tick();
        check("rst_ready", cpu_req_ready, 1'b0);
        check("rst_rvalid", cpu_rvalid, 1'b0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_mem_valid", mem_req_valid, 1'b0);
        check("rst_ram_we", {tag_we, data_we, tag_re, data_re}, 4'b0);
        reset   = 1'b0;
        ram_clr = 1'b0;
        #1;
        check("idle_ready", cpu_req_ready, 1'b1);

        // load 0x10: index 1, tag 0, word 0 -> clean miss
        issue(1'b0, 27'h0000010, 32'h0);
        check("s1_cmp_rvalid", cpu_rvalid, 1'b0);
        tick();
        check("s1_refill_valid", mem_req_valid, 1'b1);
        check("s1_refill_we", mem_we, 1'b0);
        check("s1_refill_addr", mem_addr, 23'h000001);
        tick();
        check("s1_refill_hold", {mem_req_valid, mem_addr}, {1'b1, 23'h000001});
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        check("s1_wait_no_req", mem_req_valid, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = L1;
        tick();
        mem_rvalid = 1'b0;
        #1;
        check("s1_fill_rvalid", cpu_rvalid, 1'b1);
        check("s1_fill_rdata", cpu_rdata, 32'hDEADBEEF);
        check("s1_fill_status", status_wr, 3'b001);
        check("s1_fill_we", {tag_we, data_we}, 2'b11);
        check("s1_fill_line", data_wr, L1);
        tick();

        // same load again -> hit, completion one cycle after accept
        issue(1'b0, 27'h0000010, 32'h0);
        check("s2_hit_rvalid", cpu_rvalid, 1'b1);
        check("s2_hit_rdata", cpu_rdata, 32'hDEADBEEF);
        check("s2_no_mem", mem_req_valid, 1'b0);
        tick();
        check("s2_next_ready", cpu_req_ready, 1'b1);
        check("s2_pulse_end", cpu_rvalid, 1'b0);

        // store to word 1 -> hit, merged line, dirty
        issue(1'b1, 27'h0000014, 32'h12345678);
        check("s3_rvalid", cpu_rvalid, 1'b1);
        check("s3_we", {tag_we, data_we}, 2'b11);
        check("s3_line", data_wr, L1S);
        check("s3_status", status_wr, 3'b011);
        tick();

        // load 0x4010: index 1, tag 1 -> dirty victim goes out first
        issue(1'b0, 27'h0004010, 32'h0);
        check("s4_cmp_rvalid", cpu_rvalid, 1'b0);
        tick();
        check("s4_wb_valid", {mem_req_valid, mem_we}, 2'b11);
        check("s4_wb_addr", mem_addr, 23'h000001);
        check("s4_wb_data", mem_wdata, L1S);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        check("s4_refill_req", {mem_req_valid, mem_we}, 2'b10);
        check("s4_refill_addr", mem_addr, 23'h000401);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b1;
        mem_rdata     = L2;
        tick();
        mem_rvalid = 1'b0;
        #1;
        check("s4_fill_rdata", {cpu_rvalid, cpu_rdata}, {1'b1, 32'h44440000});
        check("s4_fill_status", {tag_wr, status_wr}, {13'h1, 3'b001});
        tick();
`ifdef CACHE_STATS_EN
        check("stats_hits", hit_count, 32'd2);
        check("stats_misses", miss_count, 32'd2);
`endif

        // load 0x8010 (tag 2): clean miss, reset while waiting for refill data
        issue(1'b0, 27'h0008010, 32'h0);
        tick();
        check("s5_refill_addr", mem_addr, 23'h000801);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("s5_ready_after_rst", cpu_req_ready, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_rvalid = (i == 1);
            mem_rdata  = L3;
            #1;
            bad = bad | tag_we | data_we | cpu_rvalid | mem_req_valid;
            tick();
        end
        mem_rvalid = 1'b0;
        #1;
        check("s5_late_rvalid_ignored", bad, 1'b0);
        check("s5_still_ready", cpu_req_ready, 1'b1);

        // line from scenario 4 must be untouched by the aborted refill
        issue(1'b0, 27'h0004010, 32'h0);
        check("s6_hit_after_rst", {cpu_rvalid, cpu_rdata}, {1'b1, 32'h44440000});
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
